// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int MASK_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner select between fetch and data requesters; data wins unless fetch has
// been passed over STARVE_LIMIT times in a row.
module arb_priority_sel
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_req,
   input  logic   d_req,
   input  logic   idle,
   input  logic   grant,
   output owner_e winner
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Priority decision for the current IDLE cycle
   always_comb begin
      if (d_req && i_req) begin
         if (cnt_q == LIMIT) begin
            winner = FETCH;
         end else begin
            winner = DATA;
         end
      end else if (d_req) begin
         winner = DATA;
      end else if (i_req) begin
         winner = FETCH;
      end else begin
         winner = NONE;
      end
   end

   // Starvation count: saturating count of data grants that bypassed a waiting fetch
   always_comb begin
      cnt_d = cnt_q;
      if (grant) begin
         if ((winner == FETCH) || !i_req) begin
            cnt_d = {CNT_W{1'b0}};
         end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else if (idle && !i_req) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store traffic onto one req/gnt/rvalid
// memory port, one transaction in flight, with registered completion pulses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_kill,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [MASK_W-1:0] d_wmask,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [MASK_W-1:0] m_wmask,
   input  logic              m_gnt,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata
);

   state_e              state_q,   state_d;
   owner_e              owner_q,   owner_d;
   logic                kill_q,    kill_d;
   logic                i_rvalid_q, i_rvalid_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic                d_done_q,  d_done_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                m_req_q,   m_req_d;
   logic                m_we_q,    m_we_d;
   logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [MASK_W-1:0]   m_wmask_q, m_wmask_d;

   logic   fetch_req_s;
   logic   idle_s;
   logic   grant_s;
   owner_e winner_s;

   assign fetch_req_s = i_req & ~i_kill;
   assign idle_s      = (state_q == IDLE);
   assign grant_s     = idle_s & (fetch_req_s | d_req);

   arb_priority_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_sel (
      .clk    (clk),
      .reset  (reset),
      .i_req  (fetch_req_s),
      .d_req  (d_req),
      .idle   (idle_s),
      .grant  (grant_s),
      .winner (winner_s)
   );

   // Next-state and next-output computation for the transaction FSM
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      kill_d     = kill_q;
      i_rvalid_d = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_done_d   = 1'b0;
      d_rdata_d  = d_rdata_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      m_wmask_d  = m_wmask_q;
      case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (grant_s) begin
               owner_d = winner_s;
               state_d = REQ;
               m_req_d = 1'b1;
               if (winner_s == DATA) begin
                  m_we_d    = d_we;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_we ? d_wdata : {DATA_W{1'b0}};
                  m_wmask_d = d_we ? d_wmask : {MASK_W{1'b0}};
               end else begin
                  m_we_d    = 1'b0;
                  m_addr_d  = i_addr;
                  m_wdata_d = {DATA_W{1'b0}};
                  m_wmask_d = {MASK_W{1'b0}};
               end
            end else begin
               owner_d = NONE;
            end
         end
         REQ: begin
            kill_d = kill_q | ((owner_q == FETCH) & i_kill);
            if (m_gnt) begin
               m_req_d = 1'b0;
               if (m_we_q) begin
                  d_done_d = 1'b1;
                  state_d  = IDLE;
                  owner_d  = NONE;
                  kill_d   = 1'b0;
               end else begin
                  state_d = RESP;
               end
            end else begin
               state_d = REQ;
            end
         end
         RESP: begin
            kill_d = kill_q | ((owner_q == FETCH) & i_kill);
            if (m_rvalid) begin
               state_d = IDLE;
               owner_d = NONE;
               kill_d  = 1'b0;
               if (owner_q == DATA) begin
                  d_rdata_d = m_rdata;
                  d_done_d  = 1'b1;
               end else if (!(kill_q || i_kill)) begin
                  // a fetch flushed while in flight drains silently
                  i_rdata_d  = m_rdata;
                  i_rvalid_d = 1'b1;
               end else begin
                  i_rvalid_d = 1'b0;
               end
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = NONE;
            kill_d  = 1'b0;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= NONE;
         kill_q     <= 1'b0;
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= {DATA_W{1'b0}};
         d_done_q   <= 1'b0;
         d_rdata_q  <= {DATA_W{1'b0}};
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= {ADDR_W{1'b0}};
         m_wdata_q  <= {DATA_W{1'b0}};
         m_wmask_q  <= {MASK_W{1'b0}};
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         kill_q     <= kill_d;
         i_rvalid_q <= i_rvalid_d;
         i_rdata_q  <= i_rdata_d;
         d_done_q   <= d_done_d;
         d_rdata_q  <= d_rdata_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         m_wmask_q  <= m_wmask_d;
      end
   end

   assign i_rvalid = i_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_done   = d_done_q;
   assign d_rdata  = d_rdata_q;
   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_wmask  = m_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for the basic fetch/load
// flows plus hand-written starvation, wait-state, kill and reset sequences.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_kill;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wmask;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wmask;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_kill   (i_kill),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_wmask  (d_wmask),
      .d_done   (d_done),
      .d_rdata  (d_rdata),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wmask  (m_wmask),
      .m_gnt    (m_gnt),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        ikill;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dwmask;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        e_irv;
      logic [31:0] e_irdata;
      logic        e_ddone;
      logic [31:0] e_drdata;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic [3:0]  e_mwmask;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req    = 1'b0;
      i_addr   = 32'h0;
      i_kill   = 1'b0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = 32'h0;
      d_wdata  = 32'h0;
      d_wmask  = 4'h0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
   endtask

   task automatic wait_mreq(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((m_req !== 1'b1) && (n < 8));
      check(name, 32'(m_req), 32'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();

      //        rst   ireq  iaddr        ikill dreq  dwe   daddr        dwdata        dwmask gnt   rv    rdata          irv   irdata         ddone drdata         mreq  mwe   maddr        mwdata mwmask
      vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[2]  = '{1'b0, 1'b1, 32'h10,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h10,      32'h0, 4'h0};
      vecs[3]  = '{1'b0, 1'b1, 32'h10,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h10,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[6]  = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b1, 1'b0, 32'h100,     32'hAAAA5555, 4'hF,  1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         1'b1, 1'b0, 32'h100,     32'h0, 4'h0};
      vecs[7]  = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b1, 1'b0, 32'h100,     32'hAAAA5555, 4'hF,  1'b1, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[8]  = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b1, 1'b0, 32'h100,     32'hAAAA5555, 4'hF,  1'b0, 1'b1, 32'h11112222,  1'b0, 32'hDEADBEEF,  1'b1, 32'h11112222,  1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[9]  = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h11112222,  1'b1, 1'b0, 32'h14,      32'h0, 4'h0};
      vecs[10] = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b1, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h11112222,  1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[11] = '{1'b0, 1'b1, 32'h14,      1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b1, 32'h0BADF00D,  1'b1, 32'h0BADF00D,  1'b0, 32'h11112222,  1'b0, 1'b0, 32'h0,       32'h0, 4'h0};
      vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       32'h0,        4'h0,  1'b0, 1'b0, 32'h0,         1'b0, 32'h0BADF00D,  1'b0, 32'h11112222,  1'b0, 1'b0, 32'h0,       32'h0, 4'h0};

      for (int i = 0; i < NVEC; i++) begin
         reset    = vecs[i].rst;
         i_req    = vecs[i].ireq;
         i_addr   = vecs[i].iaddr;
         i_kill   = vecs[i].ikill;
         d_req    = vecs[i].dreq;
         d_we     = vecs[i].dwe;
         d_addr   = vecs[i].daddr;
         d_wdata  = vecs[i].dwdata;
         d_wmask  = vecs[i].dwmask;
         m_gnt    = vecs[i].gnt;
         m_rvalid = vecs[i].rv;
         m_rdata  = vecs[i].rdata;
         tick();
         check($sformatf("v%0d_i_rvalid", i), 32'(i_rvalid), 32'(vecs[i].e_irv));
         check($sformatf("v%0d_i_rdata", i),  i_rdata,        vecs[i].e_irdata);
         check($sformatf("v%0d_d_done", i),   32'(d_done),   32'(vecs[i].e_ddone));
         check($sformatf("v%0d_d_rdata", i),  d_rdata,        vecs[i].e_drdata);
         check($sformatf("v%0d_m_req", i),    32'(m_req),    32'(vecs[i].e_mreq));
         if (vecs[i].e_mreq) begin
            check($sformatf("v%0d_m_we", i),    32'(m_we),    32'(vecs[i].e_mwe));
            check($sformatf("v%0d_m_addr", i),  m_addr,        vecs[i].e_maddr);
            check($sformatf("v%0d_m_wdata", i), m_wdata,       vecs[i].e_mwdata);
            check($sformatf("v%0d_m_wmask", i), 32'(m_wmask), 32'(vecs[i].e_mwmask));
         end
      end

      // Starvation: fetch held while stores stream back-to-back
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA0; d_wmask = 4'hF;
      for (int g = 0; g < 5; g++) begin
         wait_mreq($sformatf("starve%0d_m_req", g));
         if (g < 4) begin
            check($sformatf("starve%0d_m_addr", g), m_addr, 32'h300 + 32'(4 * g));
            check($sformatf("starve%0d_m_we", g), 32'(m_we), 32'd1);
            m_gnt = 1'b1;
            tick();
            m_gnt = 1'b0;
            check($sformatf("starve%0d_d_done", g), 32'(d_done), 32'd1);
            if (g == 3) begin
               check("starve_cnt_sat", 32'(dut.u_sel.cnt_q), 32'd4);
            end
            d_addr  = 32'h300 + 32'(4 * (g + 1));
            d_wdata = 32'hA0 + 32'(g + 1);
         end else begin
            check("starve_fetch_m_addr", m_addr, 32'h40);
            check("starve_fetch_m_we", 32'(m_we), 32'd0);
            check("starve_cnt_clr", 32'(dut.u_sel.cnt_q), 32'd0);
            m_gnt = 1'b1;
            tick();
            m_gnt = 1'b0;
            m_rvalid = 1'b1; m_rdata = 32'h55AA55AA;
            tick();
            m_rvalid = 1'b0;
            check("starve_fetch_i_rvalid", 32'(i_rvalid), 32'd1);
            check("starve_fetch_i_rdata", i_rdata, 32'h55AA55AA);
            i_req = 1'b0;
            d_req = 1'b0;
         end
      end
      tick();

      // Store with three wait cycles before grant
      idle_inputs();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wmask = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("st_wait%0d_m_req", k),   32'(m_req),   32'd1);
         check($sformatf("st_wait%0d_m_addr", k),  m_addr,        32'h200);
         check($sformatf("st_wait%0d_m_wdata", k), m_wdata,       32'h12345678);
         check($sformatf("st_wait%0d_m_wmask", k), 32'(m_wmask), 32'hF);
         check($sformatf("st_wait%0d_d_done", k),  32'(d_done),  32'd0);
      end
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      check("st_d_done", 32'(d_done), 32'd1);
      check("st_m_req_drop", 32'(m_req), 32'd0);
      d_req = 1'b0;
      tick();
      check("st_d_done_pulse", 32'(d_done), 32'd0);

      // Fetch killed in RESP: response discarded
      idle_inputs();
      i_req = 1'b1; i_addr = 32'h80;
      wait_mreq("kill_m_req");
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      i_kill = 1'b1;
      tick();
      i_kill = 1'b0; i_req = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
      tick();
      m_rvalid = 1'b0;
      check("kill_i_rvalid", 32'(i_rvalid), 32'd0);
      check("kill_i_rdata", i_rdata, 32'h55AA55AA);
      tick();
      check("kill_i_rvalid_late", 32'(i_rvalid), 32'd0);

      // Next fetch after a kill completes normally
      i_req = 1'b1; i_addr = 32'h84;
      wait_mreq("postkill_m_req");
      check("postkill_m_addr", m_addr, 32'h84);
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'h13572468;
      tick();
      m_rvalid = 1'b0;
      i_req = 1'b0;
      check("postkill_i_rvalid", 32'(i_rvalid), 32'd1);
      check("postkill_i_rdata", i_rdata, 32'h13572468);
      tick();

      // Reset mid-transaction, then a stray m_rvalid
      idle_inputs();
      i_req = 1'b1; i_addr = 32'h90;
      wait_mreq("rst_m_req");
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0; i_req = 1'b0;
      check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      check("rst_i_rdata",  i_rdata,        32'd0);
      check("rst_d_done",   32'(d_done),   32'd0);
      check("rst_d_rdata",  d_rdata,        32'd0);
      check("rst_m_req",    32'(m_req),    32'd0);
      check("rst_m_we",     32'(m_we),     32'd0);
      check("rst_m_addr",   m_addr,         32'd0);
      check("rst_m_wdata",  m_wdata,        32'd0);
      check("rst_m_wmask",  32'(m_wmask),  32'd0);
      tick();
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h77777777;
      tick();
      m_rvalid = 1'b0;
      check("rst_stray_i_rvalid", 32'(i_rvalid), 32'd0);
      check("rst_stray_i_rdata",  i_rdata,        32'd0);
      check("rst_stray_d_done",   32'(d_done),   32'd0);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
